// File: rtl/isqrt_pipe.sv
// Pipelined 32-bit integer square root, y = floor(sqrt(x)), using the restoring
// digit-by-digit method with 16 iterations spread evenly over n_pipe_stages stages.
module isqrt_pipe #(
    parameter int n_pipe_stages = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y
);
    localparam int ITERS = 16 / n_pipe_stages;

    generate
        if (!(n_pipe_stages == 1 || n_pipe_stages == 2 || n_pipe_stages == 4 ||
              n_pipe_stages == 8 || n_pipe_stages == 16)) begin : g_bad_param
            $error("isqrt_pipe: n_pipe_stages must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    logic        vld_q   [n_pipe_stages];
    logic [17:0] rem_q   [n_pipe_stages];
    logic [15:0] root_q  [n_pipe_stages];
    logic [31:0] x_q     [n_pipe_stages];

    logic        vld_in  [n_pipe_stages];
    logic [17:0] rem_in  [n_pipe_stages];
    logic [15:0] root_in [n_pipe_stages];
    logic [31:0] x_in    [n_pipe_stages];

    logic [17:0] rem_d   [n_pipe_stages];
    logic [15:0] root_d  [n_pipe_stages];
    logic [31:0] x_d     [n_pipe_stages];

    // Stage inputs: stage 0 starts from rem = root = 0, later stages chain.
    always_comb begin
        vld_in[0]  = x_vld;
        rem_in[0]  = '0;
        root_in[0] = '0;
        x_in[0]    = x;
        for (int k = 1; k < n_pipe_stages; k++) begin
            vld_in[k]  = vld_q[k-1];
            rem_in[k]  = rem_q[k-1];
            root_in[k] = root_q[k-1];
            x_in[k]    = x_q[k-1];
        end
    end

    // Radicand is kept left-aligned so the next two bits are always x[31:30].
    always_comb begin
        logic [17:0] rem;
        logic [15:0] root;
        logic [31:0] xs;
        logic [17:0] trial;
        rem   = '0;
        root  = '0;
        xs    = '0;
        trial = '0;
        for (int k = 0; k < n_pipe_stages; k++) begin
            rem  = rem_in[k];
            root = root_in[k];
            xs   = x_in[k];
            for (int i = 0; i < ITERS; i++) begin
                rem   = {rem[15:0], xs[31:30]};
                xs    = {xs[29:0], 2'b00};
                trial = {root, 2'b01};
                if (rem >= trial) begin
                    rem  = rem - trial;
                    root = {root[14:0], 1'b1};
                end else begin
                    root = {root[14:0], 1'b0};
                end
            end
            rem_d[k]  = rem;
            root_d[k] = root;
            x_d[k]    = xs;
        end
    end

    // Data registers load only behind a valid argument so idle stages stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < n_pipe_stages; k++) begin
                vld_q[k]  <= 1'b0;
                rem_q[k]  <= '0;
                root_q[k] <= '0;
                x_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < n_pipe_stages; k++) begin
                vld_q[k] <= vld_in[k];
                if (vld_in[k]) begin
                    rem_q[k]  <= rem_d[k];
                    root_q[k] <= root_d[k];
                    x_q[k]    <= x_d[k];
                end
            end
        end
    end

    assign y_vld = vld_q[n_pipe_stages-1];
    assign y     = root_q[n_pipe_stages-1];

endmodule

// File: tb/tb_isqrt_pipe.sv
// Bench for isqrt_pipe: all legal stage counts run side by side on one stimulus,
// each checked every cycle against a delay-line model of floor(sqrt(x)).
module tb_isqrt_pipe;
    localparam int NCFG = 5;

    typedef struct packed {
        logic        v;
        logic [15:0] r;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        x_vld;
    logic [31:0] x;
    logic        y_vld_a [NCFG];
    logic [15:0] y_a     [NCFG];
    logic        chk_en;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Largest r with r*r <= v, found by binary search in 64-bit arithmetic.
    function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
        longint lo, hi, mid;
        lo = 0;
        hi = 65535;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= longint'(v)) lo = mid;
            else hi = mid - 1;
        end
        return lo[15:0];
    endfunction

    genvar g;
    for (g = 0; g < NCFG; g++) begin : g_dut
        localparam int N = 1 << g;

        isqrt_pipe #(.n_pipe_stages(N)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .x_vld (x_vld),
            .x     (x),
            .y_vld (y_vld_a[g]),
            .y     (y_a[g])
        );

        ent_t        hist[$];
        logic [15:0] last_y;

        // Front of the delay line is what the outputs must show after this edge.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hist.delete();
                for (int i = 0; i < N; i++) hist.push_back('{1'b0, 16'h0000});
                last_y = 16'h0000;
            end else begin
                hist.push_back('{x_vld, ref_isqrt(x)});
                void'(hist.pop_front());
                if (hist[0].v) last_y = hist[0].r;
            end
        end

        always @(negedge clk) begin
            logic exp_v;
            if (chk_en) begin
                exp_v = rst_n ? hist[0].v : 1'b0;
                n_vec++;
                if (y_vld_a[g] !== exp_v) begin
                    n_err++;
                    $display("[TB] FAIL y_vld n=%0d t=%0t: got %b expected %b", N, $time, y_vld_a[g], exp_v);
                end
                n_vec++;
                if (y_a[g] !== last_y) begin
                    n_err++;
                    $display("[TB] FAIL y n=%0d t=%0t: got %h expected %h", N, $time, y_a[g], last_y);
                end
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] d);
        @(posedge clk);
        #1;
        x_vld = v;
        x     = d;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] exp);
        for (int k = 0; k < NCFG; k++) begin
            n_vec++;
            if (y_a[k] !== exp) begin
                n_err++;
                $display("[TB] FAIL %s n=%0d: got %h expected %h", name, 1 << k, y_a[k], exp);
            end
        end
    endtask

    task automatic pulseAndCheck(input string name, input logic [31:0] d, input logic [15:0] exp);
        applyStimulus(1'b1, d);
        for (int i = 0; i < 18; i++) applyStimulus(1'b0, 32'h0);
        checkOutput(name, exp);
    endtask

    logic [31:0] pulse_x   [8] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'd1000000,
                                   32'hFFFF_FFFF, 32'hFFFE_0001, 32'd999999};
    logic [15:0] pulse_exp [8] = '{16'd0, 16'd1, 16'd3, 16'd4, 16'd1000,
                                   16'hFFFF, 16'hFFFF, 16'd999};

    logic [17:0] snap_rem  [4];
    logic [15:0] snap_root [4];
    logic [31:0] snap_x    [4];

    initial begin
        rst_n  = 1'b0;
        x_vld  = 1'b0;
        x      = 32'h0;
        chk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        checkOutput("reset_y", 16'h0000);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) pulseAndCheck($sformatf("pulse%0d", i), pulse_x[i], pulse_exp[i]);

        for (int i = 0; i < 1000; i++) applyStimulus(1'b1, $urandom());
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0);

        for (int i = 0; i < 500; i++) applyStimulus(1'($urandom_range(0, 1)), $urandom());
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0);

        // Reset lands after the second of three back-to-back arguments is taken.
        applyStimulus(1'b1, 32'd144);
        applyStimulus(1'b1, 32'd169);
        applyStimulus(1'b1, 32'd196);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NCFG; k++) begin
            n_vec++;
            if (y_vld_a[k] !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL async_rst_vld n=%0d: got %b expected 0", 1 << k, y_vld_a[k]);
            end
        end
        checkOutput("async_rst_y", 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        x_vld = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0);
        checkOutput("post_rst_idle", 16'h0000);
        pulseAndCheck("post_rst_81", 32'd81, 16'd9);

        for (int k = 0; k < 4; k++) begin
            snap_rem[k]  = g_dut[2].dut.rem_q[k];
            snap_root[k] = g_dut[2].dut.root_q[k];
            snap_x[k]    = g_dut[2].dut.x_q[k];
        end
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, $urandom());
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if ({g_dut[2].dut.rem_q[k], g_dut[2].dut.root_q[k], g_dut[2].dut.x_q[k]} !==
                    {snap_rem[k], snap_root[k], snap_x[k]}) begin
                    n_err++;
                    $display("[TB] FAIL gating stage%0d: got %h/%h/%h expected %h/%h/%h", k,
                             g_dut[2].dut.rem_q[k], g_dut[2].dut.root_q[k], g_dut[2].dut.x_q[k],
                             snap_rem[k], snap_root[k], snap_x[k]);
                end
            end
        end
        checkOutput("gating_y", 16'd9);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("[TB] FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
